// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, x/y raster counters, sync/video decode through a p_tick-aligned
// delay line, and line/frame strobes. Optional 16-bit frame counter enabled by VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned CLK_DIV    = 4,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned CW         = 10
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_tick,
  output logic          frame_tick,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned XW      = CW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  // Decode bounds carry one extra bit so a full-range display width still compares correctly
  localparam logic [XW-1:0] H_VIS    = XW'(H_DISPLAY);
  localparam logic [XW-1:0] V_VIS    = XW'(V_DISPLAY);
  localparam logic [XW-1:0] HS_BEG   = XW'(H_DISPLAY + H_FRONT);
  localparam logic [XW-1:0] HS_END   = XW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [XW-1:0] VS_BEG   = XW'(V_DISPLAY + V_FRONT);
  localparam logic [XW-1:0] VS_END   = XW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [2:0]    PIPE_RST = {1'b0, ~SYNC_POL, ~SYNC_POL};

  generate
    if (CLK_DIV < 1) begin : g_err_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIPE_DELAY > 4) begin : g_err_pipe
      $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
    end
    if (H_TOTAL > (32'd1 << CW)) begin : g_err_htotal
      $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (32'd1 << CW)) begin : g_err_vtotal
      $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
  endgenerate

  logic [DW-1:0] r_div;
  logic          r_p_tick;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_line_tick;
  logic          r_frame_tick;
  logic          w_x_wrap;
  logic          w_y_wrap;
  logic [XW-1:0] w_xe;
  logic [XW-1:0] w_ye;
  logic          w_vis;
  logic          w_hs_act;
  logic          w_vs_act;
  logic [2:0]    w_raw;
  logic [2:0]    w_out;

  // Pixel-tick divider: p_tick is registered, high for one clock per CLK_DIV clocks
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_p_tick <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div    <= '0;
      r_p_tick <= 1'b1;
    end else begin
      r_div    <= r_div + DW'(1);
      r_p_tick <= 1'b0;
    end
  end

  assign w_x_wrap = r_p_tick && (r_x == X_LAST);
  assign w_y_wrap = w_x_wrap && (r_y == Y_LAST);

  // Raster counters; strobes register alongside the wrap so they coincide with x/y becoming 0
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_line_tick  <= w_x_wrap;
      r_frame_tick <= w_y_wrap;
      if (r_p_tick) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + CW'(1);
        end else begin
          r_x <= r_x + CW'(1);
        end
      end
    end
  end

  assign w_xe     = {1'b0, r_x};
  assign w_ye     = {1'b0, r_y};
  assign w_vis    = (w_xe < H_VIS) && (w_ye < V_VIS);
  assign w_hs_act = (w_xe >= HS_BEG) && (w_xe <= HS_END);
  assign w_vs_act = (w_ye >= VS_BEG) && (w_ye <= VS_END);
  assign w_raw    = {w_vis,
                     w_hs_act ? SYNC_POL : ~SYNC_POL,
                     w_vs_act ? SYNC_POL : ~SYNC_POL};

  // Delay line keeps sync/video aligned with a pipelined pixel path; advances only on p_tick
  generate
    if (PIPE_DELAY == 0) begin : g_nopipe
      assign w_out = w_raw;
    end else begin : g_pipe
      logic [2:0] r_pipe [PIPE_DELAY];
      always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
          for (int unsigned i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= PIPE_RST;
        end else if (r_p_tick) begin
          r_pipe[0] <= w_raw;
          for (int unsigned i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_out = r_pipe[PIPE_DELAY-1];
    end
  endgenerate

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame count, wraps naturally at 16 bits
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_y_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

  assign p_tick     = r_p_tick;
  assign x          = r_x;
  assign y          = r_y;
  assign line_tick  = r_line_tick;
  assign frame_tick = r_frame_tick;
  assign video_on   = w_out[2];
  assign hsync      = w_out[1];
  assign vsync      = w_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny active-high, 3-deep, CLK_DIV=1 instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  always #5 clk = ~clk;

  logic        a_p_tick, a_video_on, a_hsync, a_vsync, a_line_tick, a_frame_tick;
  logic [9:0]  a_x, a_y;
  logic [15:0] a_frame_cnt;
  logic        b_p_tick, b_video_on, b_hsync, b_vsync, b_line_tick, b_frame_tick;
  logic [3:0]  b_x, b_y;
  logic [15:0] b_frame_cnt;

  vga_timing_gen dut_a (
    .clk_100MHz (clk),
    .reset_n    (rst_a_n),
    .p_tick     (a_p_tick),
    .x          (a_x),
    .y          (a_y),
    .video_on   (a_video_on),
    .hsync      (a_hsync),
    .vsync      (a_vsync),
    .line_tick  (a_line_tick),
    .frame_tick (a_frame_tick),
    .frame_cnt  (a_frame_cnt)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DELAY(3), .CW(4)
  ) dut_b (
    .clk_100MHz (clk),
    .reset_n    (rst_b_n),
    .p_tick     (b_p_tick),
    .x          (b_x),
    .y          (b_y),
    .video_on   (b_video_on),
    .hsync      (b_hsync),
    .vsync      (b_vsync),
    .line_tick  (b_line_tick),
    .frame_tick (b_frame_tick),
    .frame_cnt  (b_frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n_pt, n_hs, n_vs, n_vid, n_lt, n_ft, n_badgap, last_pt;
    int hs_first, hs_last, vid0, vid1, lt_x, lt_y, n_ptz, n_fcnz;
    bit found;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);

    check("a_rst_x",      int'(a_x), 0);
    check("a_rst_y",      int'(a_y), 0);
    check("a_rst_ptick",  int'(a_p_tick), 0);
    check("a_rst_hsync",  int'(a_hsync), 1);
    check("a_rst_vsync",  int'(a_vsync), 1);
    check("a_rst_video",  int'(a_video_on), 0);
    check("a_rst_ltick",  int'(a_line_tick), 0);
    check("a_rst_ftick",  int'(a_frame_tick), 0);
    check("a_rst_fcnt",   int'(a_frame_cnt), 0);
    check("b_rst_hsync",  int'(b_hsync), 0);
    check("b_rst_vsync",  int'(b_vsync), 0);

    // Instance A: first p_tick latency after release
    rst_a_n = 1'b1;
    cnt = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (a_p_tick) begin found = 1'b1; cnt = i; end
    end
    check("a_first_ptick_clocks", cnt, 4);
    check("a_x_at_first_tick", int'(a_x), 0);

    // One full line of instance A, sampling every clock
    n_pt = 0; n_hs = 0; n_vs = 0; n_vid = 0; n_lt = 0; n_ft = 0; n_badgap = 0;
    last_pt = 0; hs_first = -1; hs_last = -1; vid0 = -1; vid1 = -1; lt_x = -1; lt_y = -1;
    for (int i = 0; i < 3200; i++) begin
      if (i > 0) @(negedge clk);
      if (a_p_tick) begin
        n_pt++;
        if (i > 0 && (i - last_pt) != 4) n_badgap++;
        last_pt = i;
        if (!a_hsync) begin
          n_hs++;
          if (hs_first < 0) hs_first = int'(a_x);
          hs_last = int'(a_x);
        end
        if (!a_vsync) n_vs++;
        if (a_video_on) n_vid++;
        if (a_x == 10'd0) vid0 = int'(a_video_on);
        if (a_x == 10'd1) vid1 = int'(a_video_on);
      end
      if (a_line_tick) begin
        n_lt++;
        lt_x = int'(a_x);
        lt_y = int'(a_y);
      end
      if (a_frame_tick) n_ft++;
    end
    @(negedge clk);
    check("a_ticks_per_line", n_pt, 800);
    check("a_ptick_period_bad", n_badgap, 0);
    check("a_hsync_low_ticks", n_hs, 96);
    check("a_hsync_first_x", hs_first, 657);
    check("a_hsync_last_x", hs_last, 752);
    check("a_vsync_low_line0", n_vs, 0);
    check("a_video_ticks_line0", n_vid, 640);
    check("a_video_at_x0_fill", vid0, 0);
    check("a_video_at_x1", vid1, 1);
    check("a_line_ticks", n_lt, 1);
    check("a_line_tick_x", lt_x, 0);
    check("a_line_tick_y", lt_y, 1);
    check("a_frame_ticks_line0", n_ft, 0);
    check("a_line_end_ptick", int'(a_p_tick), 1);
    check("a_line_end_x", int'(a_x), 0);
    check("a_line_end_y", int'(a_y), 1);

    // Mid-line asynchronous reset at x=300, y=1
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (a_p_tick && a_x == 10'd300) found = 1'b1;
    end
    check("a_reach_x300", int'(found), 1);
    check("a_pre_rst_video", int'(a_video_on), 1);
    rst_a_n = 1'b0;
    #1;
    check("a_async_x",     int'(a_x), 0);
    check("a_async_y",     int'(a_y), 0);
    check("a_async_ptick", int'(a_p_tick), 0);
    check("a_async_video", int'(a_video_on), 0);
    check("a_async_hsync", int'(a_hsync), 1);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    cnt = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (a_p_tick) begin found = 1'b1; cnt = i; end
    end
    check("a_restart_ptick_clocks", cnt, 4);
    check("a_restart_x", int'(a_x), 0);
    check("a_restart_y", int'(a_y), 0);
    check("a_restart_video", int'(a_video_on), 0);
    repeat (4) @(negedge clk);
    check("a_restart_x_next", int'(a_x), 1);

    // Instance B: CLK_DIV=1, active-high sync, three-tick delay line
    rst_b_n = 1'b1;
    #1;
    check("b_ptick_first_clock", int'(b_p_tick), 0);
    @(negedge clk);
    check("b_ptick_n1", int'(b_p_tick), 1);
    check("b_x_n1", int'(b_x), 0);
    repeat (2) @(negedge clk);
    check("b_video_filling", int'(b_video_on), 0);
    check("b_hsync_filling", int'(b_hsync), 0);
    @(negedge clk);
    check("b_video_filled", int'(b_video_on), 1);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (b_frame_tick) found = 1'b1;
    end
    check("b_first_frame_tick", int'(found), 1);
    check("b_ft_line_tick", int'(b_line_tick), 1);
    check("b_ft_x", int'(b_x), 0);
    check("b_ft_y", int'(b_y), 0);
`ifdef VGA_FRAME_CNT_EN
    check("b_fcnt_first", int'(b_frame_cnt), 1);
`endif

    n_ptz = 0; n_fcnz = 0;
    for (int f = 0; f < 2; f++) begin
      n_hs = 0; n_vs = 0; n_vid = 0; n_lt = 0; n_ft = 0;
      for (int i = 0; i < 128; i++) begin
        if (i > 0) @(negedge clk);
        if (!b_p_tick) n_ptz++;
        if (b_frame_cnt != 16'd0) n_fcnz++;
        if (b_hsync) n_hs++;
        if (b_vsync) n_vs++;
        if (b_video_on) n_vid++;
        if (b_line_tick) n_lt++;
        if (b_frame_tick) n_ft++;
        if (f == 0) begin
          case (i)
            0:  check("b_video_i0",  int'(b_video_on), 0);
            3:  check("b_video_i3",  int'(b_video_on), 1);
            10: check("b_video_i10", int'(b_video_on), 1);
            11: check("b_video_i11", int'(b_video_on), 0);
            12: check("b_hsync_i12", int'(b_hsync), 0);
            13: check("b_hsync_i13", int'(b_hsync), 1);
            15: check("b_hsync_i15", int'(b_hsync), 1);
            16: check("b_hsync_i16", int'(b_hsync), 0);
            82: check("b_vsync_i82", int'(b_vsync), 0);
            83: check("b_vsync_i83", int'(b_vsync), 1);
            default: ;
          endcase
        end
      end
      @(negedge clk);
      check($sformatf("b_frame_spacing_f%0d", f), int'(b_frame_tick), 1);
      check($sformatf("b_hsync_act_f%0d", f), n_hs, 24);
      check($sformatf("b_vsync_act_f%0d", f), n_vs, 32);
      check($sformatf("b_video_f%0d", f), n_vid, 32);
      check($sformatf("b_line_ticks_f%0d", f), n_lt, 8);
      check($sformatf("b_frame_ticks_f%0d", f), n_ft, 1);
    end
    check("b_ptick_dropouts", n_ptz, 0);

`ifdef VGA_FRAME_CNT_EN
    check("b_fcnt_after_frames", int'(b_frame_cnt), 3);
    force dut_b.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_b.r_frame_cnt;
    check("b_fcnt_forced", int'(b_frame_cnt), 65535);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (b_frame_tick) found = 1'b1;
    end
    check("b_fcnt_wrap_tick", int'(found), 1);
    check("b_fcnt_wrap", int'(b_frame_cnt), 0);
`else
    check("b_fcnt_nonzero_samples", n_fcnz, 0);
`endif
    check("a_fcnt_end", int'(a_frame_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
